axi_burst_sequencer: RTL and testbench
======================================

Name: axi_burst_sequencer

Overview:
- Upstream command and data source for AXI_master. Replaces the free-running stimulus with a deterministic write-then-read-back sequencer.
- For each of NUM_BURSTS iterations it:
  - fills the master's write FIFO with a known pattern;
  - issues a write burst, then a read burst to the same address;
  - drains the read FIFO and compares every beat against the pattern.
- Reports pass/fail and a mismatch count to the bench or to a status register.

Parameters:
- DATA_WIDTH, 32, width of write_data/read_data; must be 32, 64 or 128.
- BURST_BEATS, 8, beats per burst, range 1..256.
- NUM_BURSTS, 4, write/read iterations per start, range 1..65535.
- BASE_ADDR, 32'h4000_0000, address of the first burst; must be aligned to DATA_WIDTH/8.
- SEED, 32'hA5A5_0000, pattern base value.

Ports:
- clk  in  1  sole clock, same as M_AXI_aclk
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- go  out  1  one-cycle command strobe to AXI_master
- RNW  out  1  1 = read, 0 = write; stable from go until done
- address  out  32  burst start address
- burst_length  out  8  BURST_BEATS-1 (AXI LEN encoding)
- burst_size  out  7  DATA_WIDTH/8
- increment_burst  out  1  constant 1
- clear_data_fifos  out  1  one-cycle pulse
- write_data  out  DATA_WIDTH  write FIFO data
- write_fifo_en  out  1  write FIFO push
- write_fifo_full  in  1  write FIFO full
- write_fifo_empty  in  1  write FIFO empty (unused except in assertions)
- read_data  in  DATA_WIDTH  read FIFO head; first-word-fall-through
- read_fifo_en  out  1  read FIFO pop
- read_fifo_empty  in  1  read FIFO empty
- read_fifo_full  in  1  unused
- busy  in  1  AXI_master busy
- done  in  1  AXI_master one-cycle completion pulse
- error  in  1  AXI_master error, valid with done
- test_busy  out  1  high from start acceptance until test_done
- test_done  out  1  one-cycle pulse at end of sequence
- test_pass  out  1  registered; valid from test_done until next start
- mismatch_count  out  16  saturating count of compare failures

Behaviour:
- Reset (asynchronous assert, release on clk): state IDLE; all outputs 0, except:
  - increment_burst = 1;
  - burst_size and burst_length hold their constants;
  - address = BASE_ADDR.
- Pattern: word for beat b of burst n = SEED + n*BURST_BEATS + b, computed in 32 bits, then zero-extended or truncated to DATA_WIDTH.
- Address for burst n = BASE_ADDR + n*BURST_BEATS*(DATA_WIDTH/8), modulo 2^32.
- States:
  - IDLE: on start, clear mismatch_count and the burst counter, set test_busy, go to CLEAR. start is ignored in every other state.
  - CLEAR: pulse clear_data_fifos for 1 cycle, then go to FILL.
  - FILL: assert write_fifo_en with the next word whenever write_fifo_full = 0. The beat counter advances only on a cycle where write_fifo_en = 1. After BURST_BEATS pushes, go to WR_GO.
  - WR_GO: wait for busy = 0, then drive RNW = 0 and address, and pulse go for 1 cycle. Go to WR_WAIT.
  - WR_WAIT: on done, go to ABORT if error = 1, otherwise go to RD_GO.
  - RD_GO: same as WR_GO with RNW = 1. Go to RD_WAIT.
  - RD_WAIT: on done, go to ABORT if error = 1, otherwise go to DRAIN.
  - DRAIN: while read_fifo_empty = 0, assert read_fifo_en and compare read_data with the expected word in the same cycle. On mismatch, increment mismatch_count, saturating at 16'hFFFF. After BURST_BEATS pops, go to NEXT.
  - NEXT: if the burst counter equals NUM_BURSTS-1, go to FINISH; otherwise increment the counter and go to CLEAR.
  - FINISH: pulse test_done; test_pass = (mismatch_count == 0); clear test_busy; go to IDLE.
  - ABORT: pulse test_done with test_pass = 0; leave mismatch_count unchanged; go to IDLE.
- Timing rules:
  - go is never asserted while busy = 1.
  - RNW and address change only in the WR_GO or RD_GO cycle.
  - A done that arrives in the same cycle go is asserted is ignored (stale completion).
- If the read FIFO stays empty in DRAIN, the block waits indefinitely (without SEQ_TIMEOUT_EN).
- Reset asserted mid-operation returns the block to IDLE immediately and drops all strobes. AXI_master recovery is not this block's responsibility.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A 20-bit watchdog counter runs in WR_WAIT, RD_WAIT and DRAIN. It reloads on every state change and on every read pop.
  - Terminal count 20'hFFFFF forces ABORT and sets a sticky timeout output bit (1 bit, cleared on start).
- Undefined: no counter and no timeout port; these states wait forever.

Test Plan:
- Defaults, ideal memory, start pulse → 4 write/read pairs at 0x4000_0000, 0x4000_0020, 0x4000_0040, 0x4000_0060; burst_length = 7 and burst_size = 4 on every go; test_done with test_pass = 1 and mismatch_count = 0.
- Memory model corrupts beat 3 of burst 1 (read 0xA5A5_000B returned as 0xA5A5_FFFF) → mismatch_count = 1, test_pass = 0, all 4 bursts still executed.
- write_fifo_full held high for 5 cycles mid-FILL → exactly 8 pushes per burst, no lost or duplicated words, final pass = 1.
- Slave returns SLVERR on the second write (error = 1 with done) → no further go, ABORT, test_done with test_pass = 0, mismatch_count = 0.
- Reset pulsed during RD_WAIT of burst 2, then start again → outputs return to reset values asynchronously; rerun completes with pass = 1.
- SEQ_TIMEOUT_EN defined, slave never asserts rvalid → after 2^20-1 cycles in RD_WAIT: timeout = 1, test_done with test_pass = 0.

Source files
------------

// File: rtl/axi_burst_sequencer.sv
// Deterministic write-then-read-back command/data source for AXI_master.
// Optional watchdog abort is compiled in with `define SEQ_TIMEOUT_EN.
module axi_burst_sequencer #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          BURST_BEATS = 8,
    parameter int          NUM_BURSTS  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] SEED        = 32'hA5A5_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  go,
    output logic                  RNW,
    output logic [31:0]           address,
    output logic [7:0]            burst_length,
    output logic [6:0]            burst_size,
    output logic                  increment_burst,
    output logic                  clear_data_fifos,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_fifo_en,
    input  logic                  write_fifo_full,
    input  logic                  write_fifo_empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_fifo_en,
    input  logic                  read_fifo_empty,
    input  logic                  read_fifo_full,
    input  logic                  busy,
    input  logic                  done,
    input  logic                  error,
    output logic                  test_busy,
    output logic                  test_done,
    output logic                  test_pass,
`ifdef SEQ_TIMEOUT_EN
    output logic                  timeout,
`endif
    output logic [15:0]           mismatch_count
);

    localparam int          BYTES      = DATA_WIDTH / 8;
    localparam logic [31:0] ADDR_STEP  = 32'(BURST_BEATS * BYTES);
    localparam logic [31:0] PAT_STEP   = 32'(BURST_BEATS);
    localparam logic [8:0]  LAST_BEAT  = 9'(BURST_BEATS - 1);
    localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);

    typedef enum logic [3:0] {
        IDLE, CLEAR, FILL, WR_GO, WR_WAIT, RD_GO, RD_WAIT, DRAIN, NEXT, FINISH, ABORT
    } state_t;

    state_t state, state_n;

    logic [8:0]            beat;
    logic [15:0]           burst;
    logic [31:0]           burst_addr;
    logic [31:0]           pat_base;
    logic [31:0]           word;
    logic [DATA_WIDTH-1:0] expect_word;

    // Pattern word for the current beat; burst offset is tracked incrementally.
    assign word        = pat_base + 32'(beat);
    assign expect_word = DATA_WIDTH'(word);

    assign increment_burst = 1'b1;
    assign burst_size      = 7'(BYTES);
    assign burst_length    = 8'(BURST_BEATS - 1);
    assign write_data      = write_fifo_en ? expect_word : '0;
    assign test_busy       = (state != IDLE) && (state != FINISH) && (state != ABORT);

`ifdef SEQ_TIMEOUT_EN
    logic [19:0] wdog;
    logic        waiting;
    logic        wdog_hit;

    assign waiting  = (state == WR_WAIT) || (state == RD_WAIT) || (state == DRAIN);
    assign wdog_hit = waiting && (wdog == 20'hFFFFF) && !read_fifo_en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_n          = state;
        go               = 1'b0;
        clear_data_fifos = 1'b0;
        write_fifo_en    = 1'b0;
        read_fifo_en     = 1'b0;
        test_done        = 1'b0;
        unique case (state)
            IDLE:    if (start) state_n = CLEAR;
            CLEAR: begin
                clear_data_fifos = 1'b1;
                state_n          = FILL;
            end
            FILL: if (!write_fifo_full) begin
                write_fifo_en = 1'b1;
                if (beat == LAST_BEAT) state_n = WR_GO;
            end
            WR_GO: if (!busy) begin
                go      = 1'b1;
                state_n = WR_WAIT;
            end
            WR_WAIT: if (done) state_n = error ? ABORT : RD_GO;
            RD_GO: if (!busy) begin
                go      = 1'b1;
                state_n = RD_WAIT;
            end
            RD_WAIT: if (done) state_n = error ? ABORT : DRAIN;
            DRAIN: if (!read_fifo_empty) begin
                read_fifo_en = 1'b1;
                if (beat == LAST_BEAT) state_n = NEXT;
            end
            NEXT:    state_n = (burst == LAST_BURST) ? FINISH : CLEAR;
            FINISH: begin
                test_done = 1'b1;
                state_n   = IDLE;
            end
            ABORT: begin
                test_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef SEQ_TIMEOUT_EN
        if (wdog_hit) state_n = ABORT;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat           <= '0;
            burst          <= '0;
            burst_addr     <= BASE_ADDR;
            pat_base       <= SEED;
            address        <= BASE_ADDR;
            RNW            <= 1'b0;
            mismatch_count <= '0;
            test_pass      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    beat           <= '0;
                    burst          <= '0;
                    burst_addr     <= BASE_ADDR;
                    pat_base       <= SEED;
                    mismatch_count <= '0;
                    test_pass      <= 1'b0;
                end
                FILL: if (write_fifo_en) begin
                    beat <= (beat == LAST_BEAT) ? '0 : beat + 9'd1;
                end
                DRAIN: if (read_fifo_en) begin
                    beat <= (beat == LAST_BEAT) ? '0 : beat + 9'd1;
                    if (read_data != expect_word && mismatch_count != 16'hFFFF)
                        mismatch_count <= mismatch_count + 16'd1;
                end
                NEXT: begin
                    if (burst == LAST_BURST) begin
                        test_pass <= (mismatch_count == 16'd0);
                    end else begin
                        burst      <= burst + 16'd1;
                        burst_addr <= burst_addr + ADDR_STEP;
                        pat_base   <= pat_base + PAT_STEP;
                    end
                end
                default: ;
            endcase
            // Command fields load on entry to the GO states and hold until the next command.
            if (state_n == WR_GO && state != WR_GO) begin
                address <= burst_addr;
                RNW     <= 1'b0;
            end
            if (state_n == RD_GO && state != RD_GO) RNW <= 1'b1;
            if (state_n == ABORT) test_pass <= 1'b0;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog    <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE && start) timeout <= 1'b0;
            else if (wdog_hit)          timeout <= 1'b1;
            if (state_n != state || read_fifo_en) wdog <= '0;
            else if (waiting)                     wdog <= wdog + 20'd1;
        end
    end
`endif

    // After a FIFO clear the master must present an empty write FIFO and a non-full read FIFO.
    a_clear_empties: assert property (@(posedge clk) disable iff (reset)
        (state == CLEAR) |=> (write_fifo_empty && !read_fifo_full));

endmodule

// File: tb/tb_axi_burst_sequencer.sv
// Directed bench for axi_burst_sequencer with a behavioural AXI_master/FIFO/memory model.
module tb_axi_burst_sequencer;

    localparam int          DW   = 32;
    localparam int          BB   = 8;
    localparam int          NB   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic          clk, reset, start;
    logic          go, RNW, increment_burst, clear_data_fifos;
    logic [31:0]   address;
    logic [7:0]    burst_length;
    logic [6:0]    burst_size;
    logic [DW-1:0] write_data, read_data;
    logic          write_fifo_en, write_fifo_full, write_fifo_empty;
    logic          read_fifo_en, read_fifo_empty, read_fifo_full;
    logic          busy, done, error;
    logic          test_busy, test_done, test_pass;
    logic [15:0]   mismatch_count;
`ifdef SEQ_TIMEOUT_EN
    logic          timeout;
`endif

    axi_burst_sequencer #(
        .DATA_WIDTH(DW), .BURST_BEATS(BB), .NUM_BURSTS(NB), .BASE_ADDR(BASE), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .go(go), .RNW(RNW), .address(address),
        .burst_length(burst_length), .burst_size(burst_size), .increment_burst(increment_burst),
        .clear_data_fifos(clear_data_fifos), .write_data(write_data), .write_fifo_en(write_fifo_en),
        .write_fifo_full(write_fifo_full), .write_fifo_empty(write_fifo_empty),
        .read_data(read_data), .read_fifo_en(read_fifo_en), .read_fifo_empty(read_fifo_empty),
        .read_fifo_full(read_fifo_full), .busy(busy), .done(done), .error(error),
        .test_busy(test_busy), .test_done(test_done), .test_pass(test_pass),
`ifdef SEQ_TIMEOUT_EN
        .timeout(timeout),
`endif
        .mismatch_count(mismatch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state: FIFOs, memory, in-flight transaction and logs.
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] go_addr[$];
    logic        go_rnw[$];
    bit          active, cur_rnw;
    logic [31:0] cur_addr;
    int          lat_cnt;
    int          n_go, n_wr, n_push, bad_len, busy_go, unstable, wr_cnt_bad, stall_hits;
    bit          corrupt_en, stall_en, stall_done;
    int          err_write_idx, stall_left;
    bit          p_push, p_pop, p_clear, p_go, p_rnw;
    logic [31:0] p_data, p_addr;

    task automatic clear_model();
        mem.delete(); go_addr.delete(); go_rnw.delete();
        n_go = 0; n_wr = 0; n_push = 0; bad_len = 0; busy_go = 0; unstable = 0;
        wr_cnt_bad = 0; stall_hits = 0; corrupt_en = 0; stall_en = 0; err_write_idx = 0;
    endtask

    task automatic finish_txn();
        logic [31:0] a, d;
        if (!cur_rnw) begin
            n_wr++;
            if (wq.size() != BB) wr_cnt_bad++;
            for (int b = 0; b < BB; b++) begin
                a = cur_addr + 32'(4 * b);
                if (wq.size() > 0) mem[a] = wq.pop_front();
            end
            error = (n_wr == err_write_idx);
        end else begin
            for (int b = 0; b < BB; b++) begin
                a = cur_addr + 32'(4 * b);
                d = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
                if (corrupt_en && a == 32'h4000_002C) d = 32'hA5A5_FFFF;
                rq.push_back(d);
            end
        end
        if (RNW !== cur_rnw || address !== cur_addr) unstable++;
        done = 1'b1; busy = 1'b0; active = 1'b0;
    endtask

    // Applies last cycle's committed strobes at the falling edge, then samples this cycle's.
    initial begin
        busy = 0; done = 0; error = 0; write_fifo_full = 0; read_fifo_full = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                wq.delete(); rq.delete();
                active = 0; busy = 0; done = 0; error = 0; stall_left = 0;
                write_fifo_full = 0;
                p_push = 0; p_pop = 0; p_clear = 0; p_go = 0;
            end else begin
                done = 0; error = 0;
                if (p_clear) begin wq.delete(); rq.delete(); stall_done = 0; end
                if (p_push) begin wq.push_back(p_data); n_push++; end
                if (p_pop && rq.size() > 0) void'(rq.pop_front());
                if (active) begin
                    lat_cnt--;
                    if (lat_cnt == 0) finish_txn();
                end
                if (p_go) begin
                    active = 1; busy = 1; lat_cnt = 3; cur_rnw = p_rnw; cur_addr = p_addr;
                end
                if (stall_left > 0) stall_left--;
                else if (stall_en && !stall_done && wq.size() == 4) begin
                    stall_left = 5; stall_done = 1; stall_hits++;
                end
                write_fifo_full = (stall_left > 0);
            end
            write_fifo_empty = (wq.size() == 0);
            read_fifo_empty  = (rq.size() == 0);
            read_data        = (rq.size() == 0) ? '0 : rq[0];
            #1;
            p_clear = clear_data_fifos; p_push = write_fifo_en; p_data = write_data;
            p_pop = read_fifo_en; p_go = go; p_rnw = RNW; p_addr = address;
            if (go) begin
                n_go++; go_addr.push_back(address); go_rnw.push_back(RNW);
                if (busy) busy_go++;
                if (burst_length != 8'd7 || burst_size != 7'd4) bad_len++;
            end
        end
    end

    bit          got_done, got_pass;
    logic [15:0] got_mm;

    // Pulses start and waits for test_done, or for the given go count when stop_go > 0.
    task automatic run_seq(input string tag, input int stop_go, input bit mid_start);
        got_done = 0;
        @(negedge clk); #2 start = 1;
        @(negedge clk); #2 start = 0;
        check({tag, "_busy"}, test_busy, 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #2;
            start = (mid_start && cyc == 40);
            if (stop_go > 0 && n_go >= stop_go) return;
            if (test_done) begin
                got_done = 1; got_pass = test_pass; got_mm = mismatch_count;
                start = 0;
                return;
            end
        end
        start = 0;
        check({tag, "_wait_bound"}, 0, 1);
    endtask

    function automatic int mem_errors();
        int e = 0;
        logic [31:0] a;
        for (int n = 0; n < NB; n++)
            for (int b = 0; b < BB; b++) begin
                a = BASE + 32'(32 * n + 4 * b);
                if (!mem.exists(a) || mem[a] !== SEED + 32'(BB * n + b)) e++;
            end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, {go, clear_data_fifos, write_fifo_en, read_fifo_en, test_done, test_busy}, 0);
        check({tag, "_rnw"}, RNW, 0);
        check({tag, "_addr"}, address, BASE);
        check({tag, "_consts"}, {burst_length, 1'b0, burst_size, increment_burst}, {8'd7, 1'b0, 7'd4, 1'b1});
        check({tag, "_status"}, {test_pass, mismatch_count}, 0);
        check({tag, "_wdata"}, write_data, 0);
    endtask

    initial begin
        reset = 1; start = 0;
        clear_model();
        repeat (3) @(negedge clk);
        #2 reset = 0;
        @(negedge clk); #2;
        check_reset_outputs("rst");
`ifdef SEQ_TIMEOUT_EN
        check("rst_timeout", timeout, 0);
`endif

        // Ideal memory, with a stray start mid-run that must be ignored.
        clear_model();
        run_seq("ideal", 0, 1);
        check("ideal_done", got_done, 1);
        check("ideal_pass", got_pass, 1);
        check("ideal_mm", got_mm, 0);
        check("ideal_ngo", n_go, 8);
        for (int i = 0; i < go_addr.size(); i++) begin
            check($sformatf("ideal_addr%0d", i), go_addr[i], BASE + 32'(32 * (i / 2)));
            check($sformatf("ideal_rnw%0d", i), go_rnw[i], 32'(i % 2));
        end
        check("ideal_lensize", bad_len, 0);
        check("ideal_go_busy", busy_go, 0);
        check("ideal_cmd_stable", unstable, 0);
        check("ideal_pushes", n_push, 32);
        check("ideal_mem", mem_errors(), 0);
        repeat (5) @(negedge clk); #2;
        check("ideal_pass_held", test_pass, 1);

        // Beat 3 of burst 1 corrupted on readback.
        clear_model(); corrupt_en = 1;
        run_seq("corrupt", 0, 0);
        check("corrupt_done", got_done, 1);
        check("corrupt_pass", got_pass, 0);
        check("corrupt_mm", got_mm, 1);
        check("corrupt_ngo", n_go, 8);

        // Write FIFO full for 5 cycles in the middle of every fill.
        clear_model(); stall_en = 1;
        run_seq("stall", 0, 0);
        check("stall_done", got_done, 1);
        check("stall_hits", stall_hits, 4);
        check("stall_pushes", n_push, 32);
        check("stall_per_burst", wr_cnt_bad, 0);
        check("stall_mem", mem_errors(), 0);
        check("stall_pass", got_pass, 1);

        // SLVERR on the second write burst.
        clear_model(); err_write_idx = 2;
        run_seq("slverr", 0, 0);
        check("slverr_done", got_done, 1);
        check("slverr_pass", got_pass, 0);
        check("slverr_mm", got_mm, 0);
        repeat (20) @(negedge clk);
        check("slverr_ngo", n_go, 3);

        // Asynchronous reset during RD_WAIT of burst 2, then a clean rerun.
        clear_model();
        run_seq("midrst", 6, 0);
        check("midrst_reached", n_go, 6);
        @(negedge clk); #2;
        check("midrst_in_rdwait", {busy, RNW}, 2'b11);
        reset = 1;
        #1;
        check_reset_outputs("arst");
        @(negedge clk); @(negedge clk); #2 reset = 0;
        clear_model();
        run_seq("rerun", 0, 0);
        check("rerun_done", got_done, 1);
        check("rerun_pass", got_pass, 1);
        check("rerun_ngo", n_go, 8);
        check("rerun_mem", mem_errors(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

endmodule
